// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and widths for the scan sequencer
package scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;
  localparam int PHASE_W = 2;
  localparam int BCNT_W = 4;
endpackage

// File: rtl/scan_phase_next.sv
// scan_phase_next: next enabled phase above current (circular), with wrap and empty-mask flags
module scan_phase_next
  import scan_pkg::*;
(
  input  logic [PHASE_W-1:0] phase,
  input  logic [3:0]         mask,
  output logic [PHASE_W-1:0] next,
  output logic               wrap,
  output logic               none
);
  // Descending search so the nearest set bit above phase wins; offset 4 re-selects phase itself
  always_comb begin
    next = phase;
    for (int i = 4; i >= 1; i--)
      if (mask[phase + PHASE_W'(i)]) next = phase + PHASE_W'(i);
  end
  assign none = ~|mask;
  assign wrap = !none && next <= phase;
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: blank/drive phase scanner feeding a 2-to-4 active-low decoder.
// Define SCAN_MASK_EN to add the phase_mask input that skips disabled phases.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MASK_EN
  input  logic [3:0]         phase_mask,
`endif
  output logic               en,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               wrap
);
  state_t               state;
  logic [BCNT_W-1:0]    bcnt;
  logic [DWELL_W-1:0]   dcnt, dwell_l;
  logic                 stop_pend;
  logic [PHASE_W-1:0]   pn_in, nxt;
  logic                 nwrap, none;
  logic [3:0]           mask;
`ifdef SCAN_MASK_EN
  assign mask = phase_mask;
`else
  assign mask = 4'hF;
`endif
  // From IDLE, searching above phase 3 yields the lowest enabled phase
  assign pn_in = (state == IDLE) ? PHASE_W'(3) : {a, b};
  scan_phase_next u_next (.phase(pn_in), .mask(mask), .next(nxt), .wrap(nwrap), .none(none));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      en <= 1'b1;
      {a, b} <= '0;
      busy <= 1'b0;
      wrap <= 1'b0;
      stop_pend <= 1'b0;
      bcnt <= '0;
      dcnt <= '0;
      dwell_l <= '0;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: if (start && !stop && !none) begin
          state <= BLANK;
          busy <= 1'b1;
          {a, b} <= nxt;
          dwell_l <= dwell;
          bcnt <= BCNT_W'(BLANK_CYC - 1);
          stop_pend <= 1'b0;
        end
        BLANK: begin
          stop_pend <= stop_pend | stop;
          if (bcnt == '0) begin
            state <= DRIVE;
            en <= 1'b0;
            dcnt <= dwell_l;
          end else bcnt <= bcnt - 1'b1;
        end
        DRIVE: if (dcnt != '0) begin
          dcnt <= dcnt - 1'b1;
          stop_pend <= stop_pend | stop;
        end else if (stop_pend || stop || none) begin
          state <= IDLE;
          en <= 1'b1;
          {a, b} <= '0;
          busy <= 1'b0;
          stop_pend <= 1'b0;
        end else begin
          state <= BLANK;
          en <= 1'b1;
          {a, b} <= nxt;
          wrap <= nwrap;
          bcnt <= BCNT_W'(BLANK_CYC - 1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: randomized and directed checks against a window-arithmetic scan model
module tb_scan_sequencer;
  localparam int DW = 8;
  localparam int BC = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic en, a, b, busy, wrap;
`ifdef SCAN_MASK_EN
  logic [3:0] phase_mask = 4'hF;
`endif
  int vectors = 0, miscompares = 0;
  bit act = 0;
  int t = 0, w = 1, kstop = -1;

  scan_sequencer #(.DWELL_W(DW), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dwell(dwell),
`ifdef SCAN_MASK_EN
    .phase_mask(phase_mask),
`endif
    .en(en), .a(a), .b(b), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // A scan is a train of windows of length BC+dwell+1: BC blanking cycles then the drive cycles.
  function automatic logic [4:0] expv();
    int k, r;
    if (!act) return 5'b10000;
    k = t / w;
    r = t % w;
    return {r < BC, 2'(k % 4), 1'b1, r == 0 && k > 0 && k % 4 == 0};
  endfunction

  task automatic step(input logic st, input logic sp, input logic [DW-1:0] dw, input string nm);
    logic [4:0] e;
    start = st;
    stop = sp;
    dwell = dw;
    @(posedge clk);
    if (!act) begin
      if (st && !sp) begin
        act = 1;
        t = 0;
        w = BC + int'(dw) + 1;
        kstop = -1;
      end
    end else begin
      if (sp && kstop < 0) kstop = t / w;
      t++;
      if (kstop >= 0 && t >= (kstop + 1) * w) act = 0;
    end
    @(negedge clk);
    e = expv();
    vectors++;
    if ({en, a, b, busy, wrap} !== e) begin
      miscompares++;
      $display("FAIL %s t=%0d got {en,a,b,busy,wrap}=%b expected %b", nm, t, {en, a, b, busy, wrap}, e);
    end
  endtask

  task automatic test_reset();
    #13;
    vectors++;
    if ({en, a, b, busy, wrap} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset got %b expected 10000", {en, a, b, busy, wrap});
    end
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    step(0, 0, 0, "idle_after_reset");
    step(0, 1, 0, "stop_in_idle");
  endtask

  task automatic test_full_scan();
    step(1, 0, 0, "scan_start");
    for (int i = 0; i < 14; i++) step(0, 0, 0, "scan_dwell0");
    for (int i = 0; i < 4; i++) step(0, i == 0, 0, "scan_stop");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "scan_idle");
  endtask

  task automatic test_stop_mid_drive();
    step(1, 0, 3, "stop_start");
    while (t != 9) step(0, 0, 0, "stop_run");
    step(0, 1, 0, "stop_req");
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, "stop_drain");
      if (busy && {a, b} == 2'b10) begin
        miscompares++;
        $display("FAIL stop_phase2 got phase 2 expected none");
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 3, "arst_start");
    while (t != 15) step(0, 0, 0, "arst_run");
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({en, a, b, busy, wrap} !== 5'b10000) begin
      miscompares++;
      $display("FAIL async_reset got %b expected 10000", {en, a, b, busy, wrap});
    end
    act = 0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, "arst_idle");
  endtask

  task automatic test_start_stop_and_busy();
    step(1, 1, 0, "start_and_stop");
    step(0, 0, 0, "start_and_stop_idle");
    step(1, 0, 1, "busy_start");
    for (int i = 0; i < 12; i++) step(i % 3 == 0, 0, 8'(200 + i), "start_while_busy");
    step(0, 1, 0, "busy_stop");
    for (int i = 0; i < 5; i++) step(0, 0, 0, "busy_drain");
  endtask

  task automatic test_max_dwell();
    step(1, 0, 8'hFF, "maxdwell_start");
    for (int i = 0; i < 4 * (BC + 256) + 4; i++) step(0, i == 4 * (BC + 256), 0, "maxdwell");
    for (int i = 0; i < 260; i++) step(0, 0, 0, "maxdwell_drain");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++)
      step($urandom % 6 == 0, $urandom % 50 == 0, DW'($urandom % 5), "random");
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_stop_mid_drive();
    test_async_reset();
    test_start_stop_and_busy();
    test_max_dwell();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
